// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: machine widths, instruction alignment and the
// instruction-buffer entry format.
package fetch_unit_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_ALIGN = 4;
    localparam int unsigned ALIGN_BITS  = 2;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; flush and reset take priority over
// any push or pop in the same cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential requests, in-order responses into
// a small buffer, and redirect handling that discards stale in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [ILEN-1:0] mem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned     CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] PcStep = XLEN'(INSTR_ALIGN);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   credits_used;
    logic            fifo_empty, fifo_full;
    logic            fifo_push, fifo_pop, req_fire;
    fetch_entry_t    fifo_head, fifo_wdata;

    // Every issued request already owns a buffer slot, so a response can never overflow.
    assign credits_used  = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign mem_req_valid = !rst && !redirect_valid
                         && (credits_used < (CntW+1)'(FIFO_DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign instr_valid = !rst && !fifo_empty;
    assign instruction = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign fifo_pop    = instr_valid && instr_ready;
    assign fifo_push   = mem_resp_valid && !redirect_valid && (discard_q == '0);
    assign fifo_wdata  = '{instr: mem_resp_data, pc: resp_pc_q};

    always_comb begin
        inflight_d = inflight_q;
        if (req_fire && !mem_resp_valid) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!req_fire && mem_resp_valid) begin
            inflight_d = inflight_q - CntW'(1);
        end

        fetch_pc_d = req_fire ? fetch_pc_q + PcStep : fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;

        // Everything still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            resp_pc_d  = align_pc(redirect_pc);
            discard_d  = inflight_d;
        end else if (mem_resp_valid) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CntW'(1);
            end else begin
                resp_pc_d = resp_pc_q + PcStep;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= align_pc(RESET_PC);
            resp_pc_q  <= align_pc(RESET_PC);
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (fifo_push),
        .push_data_i(fifo_wdata),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full));
    a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
        mem_resp_valid |-> (inflight_q != '0));
    a_req_aligned: assert property (@(posedge clk) disable iff (rst)
        mem_req_valid |-> (mem_req_addr[ALIGN_BITS-1:0] == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random in-order memory, queue-based
// reference model of outstanding requests and buffered instructions.
module tb_fetch_unit;

    localparam int unsigned DEPTH   = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] instr_pc;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instruction;
    logic [63:0] w_instr_pc;
    logic        w_one  = 1'b1;
    logic        w_zero = 1'b0;
    logic [63:0] w_pc0  = 64'h0;
    logic [31:0] w_d0   = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .redirect_valid(w_zero), .redirect_pc(w_pc0),
        .mem_req_valid(w_req_valid), .mem_req_ready(w_one),
        .mem_req_addr(w_req_addr), .mem_resp_valid(w_zero),
        .mem_resp_data(w_d0), .instr_valid(w_instr_valid),
        .instr_ready(w_zero), .instruction(w_instruction), .instr_pc(w_instr_pc)
    );

    typedef struct { logic [63:0] addr; bit stale; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] data; } ins_t;

    req_t        pend[$];
    ins_t        fq[$];
    logic [63:0] exp_req_addr;
    int unsigned ready_pct = 100;
    int unsigned resp_pct  = 100;
    int          n_tests   = 0;
    int          n_fail    = 0;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Reference model, updated with the values present at each rising edge.
    always @(posedge clk) begin
        req_t h;
        if (rst) begin
            pend.delete();
            fq.delete();
            exp_req_addr = 64'h0;
        end else begin
            if (instr_valid && instr_ready && fq.size() > 0) void'(fq.pop_front());
            if (mem_resp_valid && pend.size() > 0) begin
                h = pend.pop_front();
                if (!redirect_valid && !h.stale)
                    fq.push_back('{pc: h.addr, data: word_of(h.addr)});
            end
            if (mem_req_valid && mem_req_ready) begin
                pend.push_back('{addr: exp_req_addr, stale: 1'b0});
                exp_req_addr = exp_req_addr + 64'd4;
            end
            if (redirect_valid) begin
                fq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                exp_req_addr = {redirect_pc[63:2], 2'b00};
            end
        end
    end

    // In-order memory with random acceptance and response timing.
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
        end else begin
            mem_req_ready  = ($urandom_range(99) < ready_pct);
            mem_resp_valid = (pend.size() > 0) && ($urandom_range(99) < resp_pct);
            if (mem_resp_valid) mem_resp_data = word_of(pend[0].addr);
            else                mem_resp_data = $urandom;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++;
            if (mem_req_valid !== 1'b0 || w_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_req_valid got=%b/%b exp=0", mem_req_valid, w_req_valid);
            end
            n_tests++;
            if (instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid);
            end
            next_cycle();
        end
        rst = 1'b0;
        settle();
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0) begin
            n_fail++; $display("FAIL first_req got=%b/%h exp=1/0", mem_req_valid, mem_req_addr);
        end
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_instr_valid got=%b exp=0", instr_valid);
        end
        n_tests++;
        if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
            n_fail++; $display("FAIL wrap_first_req got=%b/%h exp=1/%h", w_req_valid, w_req_addr, WRAP_PC);
        end
        next_cycle();
        settle();
        n_tests++;
        if (w_req_addr !== 64'h0) begin
            n_fail++; $display("FAIL wrap_second_addr got=%h exp=0", w_req_addr);
        end
        next_cycle();
    endtask

    task automatic test_stream_and_stall();
        logic [63:0] e_pc;
        int          seen;
        bit          found;
        ready_pct = 100; resp_pct = 100; instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            settle();
            e_pc = 64'(4 * (k - 2));
            if (k < 2) begin
                n_tests++;
                if (instr_valid !== 1'b0) begin
                    n_fail++; $display("FAIL stream_warmup cyc=%0d got=%b exp=0", k, instr_valid);
                end
            end else begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr_pc !== e_pc || instruction !== word_of(e_pc)) begin
                    n_fail++;
                    $display("FAIL stream cyc=%0d got=%b/%h/%h exp=1/%h/%h", k, instr_valid, instr_pc,
                             instruction, e_pc, word_of(e_pc));
                end
            end
            next_cycle();
        end
        // 80 is the first instruction not yet consumed.
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) next_cycle();
        settle();
        n_tests++;
        if (instr_valid !== 1'b1 || mem_req_valid !== 1'b0 || instr_pc !== 64'd80) begin
            n_fail++; $display("FAIL stall_full got=%b/%b/%h exp=1/0/50", instr_valid, mem_req_valid, instr_pc);
        end
        next_cycle();
        ready_pct = 0; instr_ready = 1'b1; seen = 0;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (instr_valid === 1'b1) begin
                n_tests++;
                if (instr_pc !== 64'(80 + 4 * seen)) begin
                    n_fail++; $display("FAIL drain_pc got=%h exp=%h", instr_pc, 64'(80 + 4 * seen));
                end
                seen++;
            end
            next_cycle();
        end
        n_tests++;
        if (seen != DEPTH) begin
            n_fail++; $display("FAIL buffered_count got=%0d exp=%0d", seen, DEPTH);
        end
        ready_pct = 100; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (instr_valid === 1'b1) begin
                found = 1;
                n_tests++;
                if (instr_pc !== 64'd96) begin
                    n_fail++; $display("FAIL resume_pc got=%h exp=60", instr_pc);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL resume_timeout got=none exp=instr_valid");
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        ready_pct = 100; resp_pct = 0; instr_ready = 1'b1;
        do_reset();
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h1003;
        settle();
        n_tests++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL redirect_no_req got=%b exp=0", mem_req_valid);
        end
        next_cycle();
        redirect_valid = 1'b0; resp_pct = 100;
        settle();
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin
            n_fail++; $display("FAIL redirect_target got=%b/%h exp=1/1000", mem_req_valid, mem_req_addr);
        end
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (k != 0) settle();
            if (instr_valid === 1'b1) begin
                found = 1;
                n_tests++;
                if (instr_pc !== 64'h1000 || instruction !== word_of(64'h1000)) begin
                    n_fail++; $display("FAIL redirect_first_pc got=%h/%h exp=1000/%h", instr_pc,
                                       instruction, word_of(64'h1000));
                end
            end
            next_cycle();
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL redirect_timeout got=none exp=instr_valid");
        end
    endtask

    task automatic test_redirect_pop_resp();
        bit found;
        ready_pct = 100; resp_pct = 100; instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        settle();
        n_tests++;
        if (mem_resp_valid !== 1'b1 || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_setup got=%b/%b exp=1/1", mem_resp_valid, instr_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty got=%b exp=0", instr_valid);
        end
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2000) begin
            n_fail++; $display("FAIL flush_fetch got=%b/%h exp=1/2000", mem_req_valid, mem_req_addr);
        end
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (k != 0) settle();
            if (instr_valid === 1'b1) begin
                found = 1;
                n_tests++;
                if (instr_pc !== 64'h2000) begin
                    n_fail++; $display("FAIL flush_first_pc got=%h exp=2000", instr_pc);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL flush_timeout got=none exp=instr_valid");
        end
    endtask

    task automatic test_reset_midop();
        bit found;
        ready_pct = 100; resp_pct = 0; instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) next_cycle();
        rst = 1'b1;
        settle();
        n_tests++;
        if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL midop_rst got=%b/%b exp=0/0", mem_req_valid, instr_valid);
        end
        next_cycle();
        rst = 1'b0;
        settle();
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0) begin
            n_fail++; $display("FAIL midop_restart got=%b/%h exp=1/0", mem_req_valid, mem_req_addr);
        end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++;
            if (instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL midop_stale got=%b exp=0", instr_valid);
            end
            next_cycle();
        end
        resp_pct = 100; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (instr_valid === 1'b1) begin
                found = 1;
                n_tests++;
                if (instr_pc !== 64'h0) begin
                    n_fail++; $display("FAIL midop_first_pc got=%h exp=0", instr_pc);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL midop_timeout got=none exp=instr_valid");
        end
    endtask

    task automatic test_random();
        logic exp_rv;
        ins_t h;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (k % 60 == 0) begin
                ready_pct = $urandom_range(100, 20);
                resp_pct  = $urandom_range(100, 20);
            end
            instr_ready    = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 6);
            redirect_pc    = {$urandom, $urandom};
            if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            settle();
            exp_rv = !redirect_valid && ((pend.size() + fq.size()) < DEPTH);
            n_tests++;
            if (mem_req_valid !== exp_rv) begin
                n_fail++; $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", k, mem_req_valid, exp_rv);
            end
            if (exp_rv) begin
                n_tests++;
                if (mem_req_addr !== exp_req_addr) begin
                    n_fail++; $display("FAIL rand_req_addr cyc=%0d got=%h exp=%h", k, mem_req_addr, exp_req_addr);
                end
            end
            n_tests++;
            if (instr_valid !== (fq.size() > 0)) begin
                n_fail++; $display("FAIL rand_instr_valid cyc=%0d got=%b exp=%b", k, instr_valid, fq.size() > 0);
            end
            if (fq.size() > 0) begin
                h = fq[0];
                n_tests++;
                if (instr_pc !== h.pc || instruction !== h.data) begin
                    n_fail++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", k, instr_pc,
                                       instruction, h.pc, h.data);
                end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; instr_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        next_cycle();
        test_reset();
        test_stream_and_stall();
        test_redirect_inflight();
        test_redirect_pop_resp();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction buffer entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_valid  input  1  control-flow redirect request from downstream.
REQ-006 redirect_pc  input  64  redirect target address.
REQ-007 mem_req_valid  output  1  fetch request valid.
REQ-008 mem_req_ready  input  1  memory accepts request.
REQ-009 mem_req_addr  output  64  fetch address, always 4-byte aligned.
REQ-010 mem_resp_valid  input  1  read data valid; no ready; responses return in request order, >= 1 cycle after acceptance.
REQ-011 mem_resp_data  input  32  fetched instruction word.
REQ-012 instr_valid  output  1  instruction available to the decoder.
REQ-013 instr_ready  input  1  decoder accepts instruction.
REQ-014 instruction  output  32  instruction word driving the decoder's instruction input.
REQ-015 instr_pc  output  64  address of the presented instruction.

Function
REQ-016 Request handshake on mem_req_valid & mem_req_ready; response write and instruction pop on the respective valid(/ready) in the same edge.
REQ-017 mem_req_valid SHALL be high iff inflight + occupancy < FIFO_DEPTH, redirect_valid low and rst low; mem_req_addr = fetch_pc.
REQ-018 On request handshake: fetch_pc += 4 (modulo 2^64, wraps to 0), inflight += 1.
REQ-019 Each response SHALL decrement inflight; if discard_cnt > 0 it SHALL be dropped and discard_cnt decremented, else {mem_resp_data, resp_pc} SHALL be written to the FIFO and resp_pc += 4.
REQ-020 The credit rule (REQ-017) SHALL guarantee the FIFO never overflows; a response arriving with the FIFO full is a protocol error, flagged by assertion.
REQ-021 instr_valid = FIFO non-empty; instruction/instr_pc = FIFO head; pop on instr_valid & instr_ready.
REQ-022 A written response SHALL appear at the outputs on the cycle after mem_resp_valid (1-cycle latency).
REQ-023 With FIFO_DEPTH >= 3, a 1-cycle memory and instr_ready held high, throughput SHALL be 1 instruction/cycle.
REQ-024 Redirect (one cycle): flush FIFO; fetch_pc and resp_pc <= {redirect_pc[63:2], 2'b00}; discard_cnt <= inflight after this cycle's request/response updates; no request issued that cycle.
REQ-025 A response arriving in the redirect cycle SHALL be dropped and not counted in discard_cnt.
REQ-026 Redirect and pop in the same cycle: flush wins; the popped instruction counts as consumed by the decoder.
REQ-027 Redirect while discard_cnt > 0: discard_cnt recomputed per REQ-024 (all inflight responses stale).
REQ-028 Simultaneous push and pop SHALL leave occupancy unchanged.

Reset
REQ-029 On rst: fetch_pc = resp_pc = RESET_PC, inflight = discard_cnt = 0, FIFO empty; mem_req_valid = instr_valid = 0 during and on the cycle rst is high.
REQ-030 Reset mid-operation SHALL abandon all in-flight requests; the memory subsystem shares rst and returns no stale responses.

Structure
REQ-031 XLEN (64), ILEN (32) and instruction alignment SHALL be in the shared definitions header alongside opcodes.vh.
REQ-032 The instruction buffer SHALL be a sub-module fetch_fifo (synchronous FIFO, flush input, count output).

Verification
REQ-033 Reset, mem_req_ready=1, 1-cycle memory returning addr-derived words, instr_ready=1 -> instr_pc 0,4,8,... one per cycle from cycle 3.
REQ-034 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (4) instructions buffered, mem_req_valid low, no loss on release.
REQ-035 Redirect to 64'h1003 with 2 requests in flight -> both responses dropped, next instr_pc = 64'h1000.
REQ-036 Redirect in the same cycle as a response and a pop -> response dropped, FIFO empty next cycle, fetch from target.
REQ-037 RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 64'h0.
REQ-038 rst asserted with 3 requests in flight -> after release, first request addr = RESET_PC, instr_valid low until its response.
